// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register file dump reader.
package regfile_dump_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int REG_ADDR_W     = 5;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_NEXT = 3'd3,
    ST_FIN  = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_dump_reader_word_byte_serializer.sv
// Loads a 32-bit word and shifts it out one byte per accepted handshake;
// flags the final byte of the word back to the controlling FSM.
module word_byte_serializer
  import regfile_dump_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        shift_en,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0]      shift_q;
  logic [CNT_W-1:0] cnt_q;

  // Consumed bytes are replaced with zeros, so the register drains to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= word;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= (BIG_ENDIAN != 0) ? {shift_q[23:0], 8'h00} : {8'h00, shift_q[31:8]};
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign byte_out = (BIG_ENDIAN != 0) ? shift_q[31:24] : shift_q[7:0];
  assign last     = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register index range and streams each word as bytes over valid/ready.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum byte after the data.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [31:0]           rd_data,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic                  busy_q;
  logic                  ser_load, ser_shift, ser_last;
  logic [7:0]            ser_byte;
  logic                  at_last_reg;

  assign at_last_reg = (rd_addr_q == REG_ADDR_W'(LAST_REG));
  assign ser_shift   = (state_q == ST_SEND) && byte_ready;

  word_byte_serializer #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .word     (rd_data),
    .shift_en (ser_shift),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    ser_load   = 1'b0;
    byte_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_READ;
      ST_READ: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        byte_valid = 1'b1;
        if (byte_ready && ser_last) state_d = ST_NEXT;
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      ST_NEXT: state_d = at_last_reg ? ST_CSUM : ST_READ;
      ST_CSUM: begin
        byte_valid = 1'b1;
        if (byte_ready) state_d = ST_FIN;
      end
`else
      ST_NEXT: state_d = at_last_reg ? ST_FIN : ST_READ;
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        rd_addr_q <= REG_ADDR_W'(FIRST_REG);
        busy_q    <= 1'b1;
      end else if (state_q == ST_NEXT && !at_last_reg) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end else if (state_q == ST_FIN) begin
        busy_q <= 1'b0;
      end
    end
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of every accepted data byte; the checksum byte itself is excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      csum_q <= '0;
    end else if (ser_shift) begin
      csum_q <= csum_q ^ ser_byte;
    end
  end

  assign byte_out = (state_q == ST_CSUM) ? csum_q : ser_byte;
`else
  assign byte_out = ser_byte;
`endif

  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = (state_q == ST_FIN);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dump, stalls, ignored starts,
// mid-dump reset and a single little-endian word.
module tb_regfile_dump_reader;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, byte_ready;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  byte_out;
  logic        byte_valid, busy, done;

  logic        start2, byte_ready2;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data2;
  logic [7:0]  byte_out2;
  logic        byte_valid2, busy2, done2;

  logic [31:0] rf [0:31];
  logic [7:0]  got_b [0:255];
  int nb, ndone, done_cyc, first_vld_cyc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_data  = (rd_addr == 5'd0) ? 32'h0 : rf[rd_addr];
  assign rd_data2 = (rd_addr2 == 5'd5) ? 32'hDEADBEEF : 32'h0;

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .BIG_ENDIAN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .done(done)
  );

  regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(5), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .rst_n(rst_n), .start(start2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .byte_out(byte_out2), .byte_valid(byte_valid2), .byte_ready(byte_ready2),
    .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    int r;
    r = k / 4;
    w = (r == 0) ? 32'h0 : rf[r];
    return w[31 - 8 * (k % 4) -: 8];
  endfunction

  // mode 0: ready held high; mode 1: random ready with two forced 10-cycle stalls
  task automatic run_dump(input int mode, input bit repulse, input int max_cyc);
    int stall_cnt, tail;
    bit prev_stall, seen_done;
    logic [7:0] prev_byte;
    nb = 0; ndone = 0; done_cyc = -1; first_vld_cyc = -1;
    stall_cnt = 0; tail = 0; prev_stall = 0; seen_done = 0; prev_byte = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (repulse && (cyc == 10 || done));
      if (mode == 0) byte_ready = 1'b1;
      else if (stall_cnt > 0) begin byte_ready = 1'b0; stall_cnt--; end
      else if (cyc == 20 || cyc == 100) begin byte_ready = 1'b0; stall_cnt = 9; end
      else byte_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        check("stall_valid", 32'(byte_valid), 32'd1);
        check("stall_byte", 32'(byte_out), 32'(prev_byte));
      end
      if (cyc == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (byte_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (byte_valid && byte_ready && nb < 256) begin got_b[nb] = byte_out; nb++; end
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_out;
      if (done) begin
        ndone++;
        if (!seen_done) begin done_cyc = cyc; check("busy_at_done", 32'(busy), 32'd1); end
        seen_done = 1;
      end else if (seen_done) begin
        tail++;
        if (tail == 1) check("busy_after_done", 32'(busy), 32'd0);
        if (byte_valid) check("valid_after_done", 32'(byte_valid), 32'd0);
        if (tail == 6) break;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen_done), 32'd1);
  endtask

  task automatic check_dump(input string tag);
    logic [7:0] x;
    int mism;
    x = '0; mism = 0;
    check({tag, "_nbytes"}, 32'(nb), 32'(128 + CS));
    check({tag, "_ndone"}, 32'(ndone), 32'd1);
    for (int k = 0; k < 128; k++) begin
      x ^= exp_byte(k);
      if (k < nb) check({tag, "_byte"}, 32'(got_b[k]), 32'(exp_byte(k)));
    end
    if (CS != 0 && nb > 128) check({tag, "_csum"}, 32'(got_b[128]), 32'(x));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h11223300 + i;
    rst_n = 1'b0; start = 1'b0; byte_ready = 1'b0; start2 = 1'b0; byte_ready2 = 1'b0;
    #1;
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full dump, ready high
    run_dump(0, 1'b0, 2000);
    check_dump("full");
    check("first_valid_cyc", 32'(first_vld_cyc), 32'd2);
    check("done_cyc", 32'(done_cyc), 32'(193 + CS));
    check("b0_x0", 32'(got_b[0]), 32'h00);
    check("b4_x1", 32'(got_b[4]), 32'h11);
    check("b7_x1", 32'(got_b[7]), 32'h01);

    // Random ready with long stalls
    run_dump(1, 1'b0, 3000);
    check_dump("stall");

    // Start re-pulsed mid-dump and in the FIN cycle
    run_dump(0, 1'b1, 2000);
    check_dump("repulse");
    check("repulse_done_cyc", 32'(done_cyc), 32'(193 + CS));
    check("repulse_idle_busy", 32'(busy), 32'd0);

    // Reset during the third byte of x7
    @(negedge clk);
    start = 1'b1; byte_ready = 1'b1;
    repeat (46) begin @(negedge clk); start = 1'b0; end
    check("x7_b2_valid", 32'(byte_valid), 32'd1);
    check("x7_b2_byte", 32'(byte_out), 32'h33);
    check("x7_addr", 32'(rd_addr), 32'd7);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(byte_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_dump(0, 1'b0, 2000);
    check_dump("after_rst");

    // Single little-endian word from x5
    begin
      logic [7:0] le [0:7];
      int n2, d2;
      logic [31:0] exp_le;
      n2 = 0; d2 = 0;
      @(negedge clk);
      start2 = 1'b1; byte_ready2 = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        start2 = 1'b0;
        if (byte_valid2 && byte_ready2 && n2 < 8) begin le[n2] = byte_out2; n2++; end
        if (done2) d2++;
      end
      check("le_nbytes", 32'(n2), 32'(4 + CS));
      check("le_ndone", 32'(d2), 32'd1);
      exp_le = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++)
        if (k < n2) check("le_byte", 32'(le[k]), 32'(exp_le[8*k +: 8]));
      if (CS != 0 && n2 > 4) check("le_csum", 32'(le[4]), 32'h22);
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'h000000FF;
    rf[2] = 32'h0000000F;
    run_dump(0, 1'b0, 2000);
    check_dump("csum");
    if (nb > 128) check("csum_f0", 32'(got_b[128]), 32'hF0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
